keypad_scanner: RTL
===================

Name: keypad_scanner

Overview:
- Reader end of the 4x4 matrix keypad interface (Pmod KYPD style).
- Drives the column lines one at a time, samples the row lines, debounces, and decodes the pressed key to a 4-bit hex code.
- Emits one single-cycle strobe per physical press.
- Sits between the board keypad pins and the guessing-game datapath; the game top instantiates it wherever a mode needs keypad entry.

Parameters:
- SCAN_CYCLES, 100000: clocks each column is driven low before its rows are sampled (1 ms at 100 MHz); must be >= 2.
- DEBOUNCE_CYCLES, 1000000: consecutive stable clocks required to accept a press or a release (10 ms at 100 MHz); must be >= 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scan enable; low parks the block idle.
- row  input  4  keypad row lines, active-low, pulled up externally, asynchronous to clk.
- col  output  4  keypad column drives, active-low, one-hot-low while scanning.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  single-cycle strobe: key_code updated this cycle.
- key_held  output  1  high while the accepted key remains pressed.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset values: col=4'b1110 (col_idx 0), key_code=4'h0, key_valid=0, key_held=0, FSM=SCAN, all counters 0, synchroniser flops 4'b1111.
- Row synchronisation: row passes through a 2-flop synchroniser. All decisions below use the synchronised value, rs.
- Indexing: col_idx 0..3 is left to right and drives col[col_idx] low. Row index 0..3 is top to bottom and corresponds to rs[0..3].
- Decode (row r, col k -> code):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- SCAN state:
  - Dwell counter runs 0..SCAN_CYCLES-1 with the current column driven; rs is sampled on the last dwell cycle.
  - Exactly one rs bit low: latch row_idx and pattern, go to DEBOUNCE. The column stays driven.
  - rs==4'b1111 or more than one bit low (ghosting or multi-press): ignore, advance col_idx (3 wraps to 0), restart dwell.
- DEBOUNCE state:
  - Stable counter increments each cycle rs equals the latched pattern.
  - Any mismatch returns to SCAN, advances col_idx, and emits no strobe.
  - When the count reaches DEBOUNCE_CYCLES: key_code<=decoded value, key_valid=1 for exactly one cycle, key_held<=1, go to PRESSED.
  - Latency: if the sample occurs in cycle T and rs stays stable, key_valid is high in cycle T+DEBOUNCE_CYCLES+1.
- PRESSED state:
  - Column stays driven; key_held=1; no further strobes however long the key is held.
  - Release counter counts consecutive cycles of rs==4'b1111 and restarts from 0 on any low bit (release bounce).
  - When the count reaches DEBOUNCE_CYCLES: key_held<=0, advance col_idx, go to SCAN.
  - key_code keeps its value until the next accepted press.
- Enable:
  - en low in any state: next cycle FSM=SCAN, col=4'b1111, counters cleared, key_held=0, key_valid=0. key_code is retained.
  - en rising: scanning restarts at col_idx 0.
  - A key held across an en toggle is re-detected and strobes again after a full debounce.
- Simultaneous events: a second key pressed while in PRESSED is ignored until the first is released and rescanned.
- Reset mid-operation: immediate return to reset values. A pending strobe is dropped.

Test Plan:
(All scenarios use SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.)
1. Idle after reset, en=1, row=4'b1111 -> col cycles 1110,1101,1011,0111,1110, 4 clocks each; key_valid never asserts; key_code=0.
2. Hold row[1] low whenever col=1011 (key 6) for 40 clocks, then release -> exactly one key_valid pulse with key_code=6 at sample+9 cycles; key_held high until 8 clean released cycles elapse, then col resumes at 0111.
3. Press key at r3/k1 with bounce (toggle row[3] every 3 clocks for 12 clocks, then stable 20 clocks) -> no strobe during the bounce; one strobe with key_code=F after the stable run.
4. Glitch: row[0] low for 5 clocks at col=1110 -> return to SCAN, no key_valid, key_code unchanged.
5. Two rows low at the same sample (row=4'b1100 at col=1101) -> ignored, column advances, no strobe.
6. Assert rst or drop en while in PRESSED for key A -> col=1110 (rst) or 1111 (en), key_held=0; after rst key_code=0, after en drop key_code stays A; a still-held key re-strobes once after rescan.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad reader: column scan, row synchroniser, press/release debounce
// and hex decode. Produces one key_valid strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 100000,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED} state_t;

  state_t        state_q, state_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [SW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    pattern_q, pattern_d;
  logic [1:0]    row_idx_q, row_idx_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_held_q, key_held_d;
  logic [3:0]    col_q, col_d;
  logic [3:0]    sync1_q, rs_q;

  logic [3:0]    low;
  logic          one_low;
  logic [1:0]    low_idx;

  // Rows are asynchronous to clk; only rs_q is used past this point.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 4'hF;
      rs_q    <= 4'hF;
    end else begin
      sync1_q <= row;
      rs_q    <= sync1_q;
    end
  end

  always_comb begin
    low     = ~rs_q;
    one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (low[i]) low_idx = 2'(i);
    end
  end

  function automatic logic [3:0] decode(input logic [1:0] r, input logic [1:0] k);
    logic [3:0] code;
    case ({r, k})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    dwell_d     = dwell_q;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    row_idx_d   = row_idx_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;

    if (!en) begin
      state_d    = SCAN;
      col_idx_d  = 2'd0;
      dwell_d    = '0;
      cnt_d      = '0;
      key_held_d = 1'b0;
    end else begin
      case (state_q)
        SCAN: begin
          if (dwell_q == SCAN_LAST) begin
            dwell_d = '0;
            // Ghosting and multi-press patterns are skipped, not debounced.
            if (one_low) begin
              state_d   = DEBOUNCE;
              pattern_d = rs_q;
              row_idx_d = low_idx;
              cnt_d     = '0;
            end else begin
              col_idx_d = col_idx_q + 2'd1;
            end
          end else begin
            dwell_d = dwell_q + SW'(1);
          end
        end
        DEBOUNCE: begin
          if (rs_q == pattern_q) begin
            if (cnt_q == DEB_LAST) begin
              state_d     = PRESSED;
              cnt_d       = '0;
              key_code_d  = decode(row_idx_q, col_idx_q);
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d   = SCAN;
            cnt_d     = '0;
            dwell_d   = '0;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        PRESSED: begin
          // Any low bit during release restarts the clean-release count.
          if (rs_q == 4'hF) begin
            if (cnt_q == DEB_LAST) begin
              state_d    = SCAN;
              cnt_d      = '0;
              dwell_d    = '0;
              key_held_d = 1'b0;
              col_idx_d  = col_idx_q + 2'd1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: state_d = SCAN;
      endcase
    end

    col_d = en ? ~(4'b0001 << col_idx_d) : 4'b1111;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      col_idx_q   <= 2'd0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      pattern_q   <= 4'hF;
      row_idx_q   <= 2'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
      col_q       <= 4'b1110;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      pattern_q   <= pattern_d;
      row_idx_q   <= row_idx_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
      col_q       <= col_d;
    end
  end

  assign col       = col_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule
